// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan controller.
// The state encoding is fixed so that debug probes on the state register read back consistently.
package mux_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter value seen on the last settle cycle for a given settle length.
  function automatic logic [CNT_W-1:0] settle_term(input int unsigned settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/scan_settle_cnt.sv
// Settle-time counter: clears on entry to a settle window, counts while enabled,
// and flags the final settle cycle.
module scan_settle_cnt
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] TERM_CNT = settle_term(SETTLE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == TERM_CNT);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the select lines of a downstream 4-to-1 mux, waits SETTLE cycles per channel,
// and captures the mux output into a 4-bit result vector.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cont,
  input  logic            f,
  output logic            s1,
  output logic            s0,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] result
);

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [N_CH-1:0]  result_q;
  logic [N_CH-1:0]  result_d;
  logic [N_CH-1:0]  ch_hit;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_term;
  logic             sample_en;
  logic             result_clr;

  scan_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    sample_en  = 1'b0;
    result_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETTLE;
          sel_d      = '0;
          cnt_clr    = 1'b1;
          result_clr = 1'b1;
        end
      end
      S_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_term) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        sample_en = 1'b1;
        if (sel_q == LAST_SEL) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          sel_d   = sel_q + 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_DONE: begin
        // Continuous mode restarts directly; the old result stays visible through the done cycle.
        if (cont) begin
          state_d    = S_SETTLE;
          sel_d      = '0;
          cnt_clr    = 1'b1;
          result_clr = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_result
    assign ch_hit[gi]   = sample_en && (sel_q == SEL_W'(gi));
    assign result_d[gi] = result_clr ? 1'b0 : (ch_hit[gi] ? f : result_q[gi]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  assign s1     = sel_q[1];
  assign s0     = sel_q[0];
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl driving a delayed 4-to-1 mux; expected scans are queued by the
// stimulus and matched against done pulses by independent monitors.
module tb_mux_scan_ctrl;

  localparam int SET_A = 3;
  localparam int SET_B = 1;

  typedef struct {
    logic [3:0] res;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, cont_a, f_a, s1_a, s0_a, busy_a, done_a;
  logic start_b, cont_b, f_b, s1_b, s0_b, busy_b, done_b;
  logic [3:0] result_a, result_b;
  logic [3:0] data_a, data_b;   // bit i is the mux input routed when {s1,s0}=i (x,y,z,v)
  logic       f_mux_a, glitch_a;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sum-of-products 4-to-1 mux with 17 ns select/data-to-output delay.
  assign #17 f_mux_a = (~s1_a & ~s0_a & data_a[0]) | (~s1_a & s0_a & data_a[1]) |
                       ( s1_a & ~s0_a & data_a[2]) | ( s1_a & s0_a & data_a[3]);
  assign f_a = f_mux_a ^ glitch_a;
  assign #17 f_b = (~s1_b & ~s0_b & data_b[0]) | (~s1_b & s0_b & data_b[1]) |
                   ( s1_b & ~s0_b & data_b[2]) | ( s1_b & s0_b & data_b[3]);

  mux_scan_ctrl #(.SETTLE(SET_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .f(f_a),
    .s1(s1_a), .s0(s0_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  mux_scan_ctrl #(.SETTLE(SET_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .f(f_b),
    .s1(s1_b), .s0(s0_b), .busy(busy_b), .done(done_b), .result(result_b)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: channel i of the result is whatever the mux routes for select value i.
  function automatic logic [3:0] ref_scan(input logic [3:0] mux_in);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = mux_in[i];
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitors: each done pulse consumes one expected scan.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      $display("done_a cycle=%0d result=%b sel=%0d", cyc, result_a, {s1_a, s0_a});
      if (exp_a.size() == 0) begin
        chk("done_a_unexpected", 1, 0);
      end else begin
        e = exp_a.pop_front();
        chk("done_a_result", int'(result_a), int'(e.res));
        chk("done_a_cycle", cyc, e.due);
        chk("done_a_sel_last", int'({s1_a, s0_a}), 3);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b) begin
      $display("done_b cycle=%0d result=%b sel=%0d", cyc, result_b, {s1_b, s0_b});
      if (exp_b.size() == 0) begin
        chk("done_b_unexpected", 1, 0);
      end else begin
        e = exp_b.pop_front();
        chk("done_b_result", int'(result_b), int'(e.res));
        chk("done_b_cycle", cyc, e.due);
      end
    end
  end

  // One scan on dut_a with optional f glitches placed inside each channel's settle window.
  task automatic scan_a(input logic [3:0] d, input bit do_glitch);
    int e0;
    data_a  = d;
    start_a = 1'b1;
    e0      = cyc + 1;
    exp_a.push_back('{res: ref_scan(d), due: e0 + 4 * (SET_A + 1)});
    step(1);
    start_a = 1'b0;
    for (int k = 0; k < 17; k++) begin
      glitch_a = do_glitch && ((k % 4) == 1);
      step(1);
    end
    glitch_a = 1'b0;
  endtask

  task automatic scan_b(input logic [3:0] d);
    data_b  = d;
    start_b = 1'b1;
    exp_b.push_back('{res: ref_scan(d), due: cyc + 1 + 4 * (SET_B + 1)});
    step(1);
    start_b = 1'b0;
    step(9);
  endtask

  initial begin
    int busy_cnt, done_cnt, e0, gap;
    rst_n = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; glitch_a = 1'b0; data_a = 4'b0000;
    start_b = 1'b0; cont_b = 1'b0; data_b = 4'b0000;
    step(3);

    // Reset state
    chk("rst_s1_a", int'(s1_a), 0);
    chk("rst_s0_a", int'(s0_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_result_a", int'(result_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    rst_n = 1'b1;
    step(2);

    // x=1 y=0 z=1 v=1 -> 1101, with settle-window glitches on f
    scan_a(4'b1101, 1'b1);
    step(2);
    chk("idle_hold_result", int'(result_a), 4'b1101);
    chk("idle_hold_sel", int'({s1_a, s0_a}), 3);

    // start held across the whole busy window: one scan, 17 busy cycles
    data_a  = 4'b0101;
    start_a = 1'b1;
    e0      = cyc + 1;
    exp_a.push_back('{res: ref_scan(4'b0101), due: e0 + 16});
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      if (i == 17) start_a = 1'b0;
    end
    chk("hold_busy_cycles", busy_cnt, 17);
    chk("hold_done_pulses", done_cnt, 1);

    // Continuous mode: 0,1,1,0 twice, then data 1,1,1,1
    data_a  = 4'b0110;
    cont_a  = 1'b1;
    start_a = 1'b1;
    e0      = cyc + 1;
    exp_a.push_back('{res: ref_scan(4'b0110), due: e0 + 16});
    exp_a.push_back('{res: ref_scan(4'b0110), due: e0 + 33});
    exp_a.push_back('{res: ref_scan(4'b1111), due: e0 + 50});
    step(1);
    start_a = 1'b0;
    step(33);
    data_a = 4'b1111;
    step(1);
    cont_a = 1'b0;
    step(20);
    chk("cont_stopped_busy", int'(busy_a), 0);

    // Reset six cycles into a scan, then a start on the first released edge
    data_a  = 4'b0111;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(5);
    rst_n = 1'b0;
    step(1);
    chk("abort_s1", int'(s1_a), 0);
    chk("abort_s0", int'(s0_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_result", int'(result_a), 0);
    rst_n = 1'b1;
    scan_a(4'b0111, 1'b0);
    step(2);

    // Randomized single scans with random idle gaps
    for (int n = 0; n < 8; n++) begin
      gap = int'($urandom_range(0, 3));
      step(gap);
      scan_a(4'($urandom), 1'b1);
    end

    // SETTLE=1 instance
    $display("NOTE dut_b SETTLE=1: settle window of 10 ns is shorter than the 17 ns mux delay (logged only)");
    scan_b(4'b1001);
    for (int n = 0; n < 4; n++) begin
      step(int'($urandom_range(0, 2)));
      scan_b(4'($urandom));
    end

    step(5);
    chk("pending_a", exp_a.size(), 0);
    chk("pending_b", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
